// File: rtl/pipe_pkg.sv
// Shared field widths and control-bit layout for the in-order pipeline stage registers.
package pipe_pkg;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam int CTRL_ALUSRC   = 0;
  localparam int CTRL_ALUOP_LO = 1;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_MEMREAD  = 5;
  localparam int CTRL_MEMWRITE = 6;
  localparam int CTRL_MEMTOREG = 7;

  // rda, rdb, imm, wa, funct7, funct3, ra1, ra2
  localparam int ID_EX_DATA_W = 3*XLEN + REG_AW + 1 + 3 + 2*REG_AW;
  localparam int ID_EX_CTRL_W = 8;
endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready stage register with optional 2-entry skid, flush and async reset.
// The top CLR_W bits of the word are control and are zeroed whenever an entry is vacated.
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter int CLR_W   = 1,
  parameter int SKID_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         r_m_valid;
  logic [W-1:0] r_m_data;
  logic         w_accept;
  logic         w_consume;

  assign w_accept  = in_valid & in_ready;
  assign w_consume = r_m_valid & out_ready;
  assign out_valid = r_m_valid;
  assign out_data  = r_m_data;

  generate
    if (SKID_EN != 0) begin : g_skid
      logic         r_s_valid;
      logic [W-1:0] r_s_data;

      // in_ready comes straight from the skid flag, so out_ready never reaches it
      assign in_ready = ~r_s_valid;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
          r_s_valid <= 1'b0;
          r_s_data  <= '0;
        end else if (flush) begin
          r_m_valid               <= 1'b0;
          r_s_valid               <= 1'b0;
          r_m_data[W-1 -: CLR_W] <= '0;
          r_s_data[W-1 -: CLR_W] <= '0;
        end else if (r_s_valid) begin
          if (w_consume) begin
            r_m_data                <= r_s_data;
            r_s_valid               <= 1'b0;
            r_s_data[W-1 -: CLR_W] <= '0;
          end
        end else if (w_accept) begin
          if (!r_m_valid || w_consume) begin
            r_m_valid <= 1'b1;
            r_m_data  <= in_data;
          end else begin
            r_s_valid <= 1'b1;
            r_s_data  <= in_data;
          end
        end else if (w_consume) begin
          r_m_valid               <= 1'b0;
          r_m_data[W-1 -: CLR_W] <= '0;
        end
      end
    end else begin : g_noskid
      assign in_ready = ~r_m_valid | out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_m_valid <= 1'b0;
          r_m_data  <= '0;
        end else if (flush) begin
          r_m_valid               <= 1'b0;
          r_m_data[W-1 -: CLR_W] <= '0;
        end else if (w_accept) begin
          r_m_valid <= 1'b1;
          r_m_data  <= in_data;
        end else if (w_consume) begin
          r_m_valid               <= 1'b0;
          r_m_data[W-1 -: CLR_W] <= '0;
        end
      end
    end
  endgenerate
endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID/EX stage register: decode payload and control into execute with handshake,
// optional skid buffering, flush-to-bubble, and control gated to zero on bubbles.
module id_ex_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = ID_EX_DATA_W,
  parameter int CTRL_W  = ID_EX_CTRL_W,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
);
  localparam int W = DATA_W + CTRL_W;

  logic [W-1:0] w_out_word;
  logic         w_out_valid;

  pipe_skid_buf #(
    .W       (W),
    .CLR_W   (CTRL_W),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({in_ctrl, in_data}),
    .flush     (flush),
    .out_valid (w_out_valid),
    .out_ready (out_ready),
    .out_data  (w_out_word)
  );

  assign out_valid = w_out_valid;
  assign out_data  = w_out_word[DATA_W-1:0];
  // Bubbles must never carry regwrite/memwrite/branch into execute
  assign out_ctrl  = w_out_valid ? w_out_word[W-1 -: CTRL_W] : '0;
endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Bench for id_ex_pipe_stage: vector table on the skid variant, reset, random ordering
// scoreboard with bubble checks, and a short sequence on the single-entry variant.
module tb_id_ex_pipe_stage;
  import pipe_pkg::*;
  localparam int DW = ID_EX_DATA_W;
  localparam int CW = ID_EX_CTRL_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic          z_in_valid, z_in_ready, z_flush, z_out_valid, z_out_ready;
  logic [DW-1:0] z_in_data, z_out_data;
  logic [CW-1:0] z_in_ctrl, z_out_ctrl;

  always #5 clk = ~clk;

  id_ex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ctrl(in_ctrl), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl));

  id_ex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .in_ctrl(z_in_ctrl), .flush(z_flush), .out_valid(z_out_valid), .out_ready(z_out_ready),
    .out_data(z_out_data), .out_ctrl(z_out_ctrl));

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          fl;
    logic          ordy;
    logic          eov;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          erdy;
  } vec_t;

  vec_t          vq[$];
  logic [DW-1:0] sb[$];
  int            n_tests = 0;
  int            n_fail  = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(bit iv, bit [DW-1:0] d, bit [CW-1:0] c, bit fl, bit ordy,
                              bit eov, bit [DW-1:0] ed, bit [CW-1:0] ec, bit erdy);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.fl = fl; v.ordy = ordy;
    v.eov = eov; v.ed = ed; v.ec = ec; v.erdy = erdy;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] seq;
    logic [DW-1:0] ones;
    ones = '1;
    in_valid = 0; in_data = '0; in_ctrl = '0; flush = 0; out_ready = 0;
    z_in_valid = 0; z_in_data = '0; z_in_ctrl = '0; z_flush = 0; z_out_ready = 0;

    // columns: in_valid data ctrl flush out_ready | out_valid out_data out_ctrl in_ready
    vq.push_back(mk(1, 'h1, 8'h08, 0, 1,  1, 'h1, 8'h08, 1));
    vq.push_back(mk(1, 'h2, 8'h08, 0, 1,  1, 'h2, 8'h08, 1));
    vq.push_back(mk(1, 'h3, 8'h08, 0, 1,  1, 'h3, 8'h08, 1));
    vq.push_back(mk(0, 'h0, 8'h00, 0, 1,  0, 'h0, 8'h00, 1));
    vq.push_back(mk(1, 'hA, 8'h09, 0, 0,  1, 'hA, 8'h09, 1));
    vq.push_back(mk(1, 'hB, 8'h0A, 0, 0,  1, 'hA, 8'h09, 0));
    vq.push_back(mk(1, 'hC, 8'h0B, 0, 0,  1, 'hA, 8'h09, 0));
    vq.push_back(mk(1, 'hC, 8'h0B, 0, 1,  1, 'hB, 8'h0A, 1));
    vq.push_back(mk(1, 'hC, 8'h0B, 0, 1,  1, 'hC, 8'h0B, 1));
    vq.push_back(mk(0, 'h0, 8'h00, 0, 1,  0, 'h0, 8'h00, 1));
    vq.push_back(mk(1, 'hA, 8'h18, 0, 0,  1, 'hA, 8'h18, 1));
    vq.push_back(mk(1, 'hB, 8'h28, 0, 0,  1, 'hA, 8'h18, 0));
    vq.push_back(mk(1, 'hC, 8'h48, 1, 0,  0, 'h0, 8'h00, 1));
    vq.push_back(mk(0, 'h0, 8'h00, 0, 1,  0, 'h0, 8'h00, 1));
    vq.push_back(mk(1, 'h55, 8'hFF, 1, 1, 0, 'h0, 8'h00, 1));
    vq.push_back(mk(1, 'h77, 8'hFF, 0, 1, 1, 'h77, 8'hFF, 1));
    vq.push_back(mk(0, 'h0, 8'hFF, 0, 1,  0, 'h0, 8'h00, 1));
    vq.push_back(mk(1, ones, 8'hFF, 0, 1, 1, ones, 8'hFF, 1));
    vq.push_back(mk(0, 'h0, 8'h00, 1, 1,  0, 'h0, 8'h00, 1));

    #2 rst = 1;
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_ctrl", out_ctrl, 0);
    chk("reset out_data", out_data, 0);
    chk("reset z_out_valid", z_out_valid, 0);
    @(posedge clk);
    @(negedge clk) rst = 0;
    #1 chk("post-reset in_ready", in_ready, 1);

    foreach (vq[i]) begin
      in_valid = vq[i].iv; in_data = vq[i].d; in_ctrl = vq[i].c;
      flush = vq[i].fl; out_ready = vq[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), out_valid, vq[i].eov);
      chk($sformatf("vec%0d out_ctrl", i), out_ctrl, vq[i].ec);
      chk($sformatf("vec%0d in_ready", i), in_ready, vq[i].erdy);
      if (vq[i].eov) chk($sformatf("vec%0d out_data", i), out_data, vq[i].ed);
    end
    flush = 0;

    // Reset in the middle of a stalled burst
    out_ready = 0; in_valid = 1; in_ctrl = 8'h08;
    for (int k = 0; k < 3; k++) begin
      in_data = DW'(32'h31 + k);
      @(posedge clk); #1;
    end
    chk("burst main", out_data, 'h31);
    chk("burst in_ready", in_ready, 0);
    #2 rst = 1;
    #1;
    chk("async rst out_valid", out_valid, 0);
    chk("async rst out_ctrl", out_ctrl, 0);
    in_valid = 0;
    @(negedge clk) rst = 0;
    #1;
    chk("rst release in_ready", in_ready, 1);
    chk("rst release out_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("rst idle out_valid", out_valid, 0);

    // Random traffic: FIFO order scoreboard and bubble gating
    seq = 'h100;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(posedge clk); #1;
      in_valid  = (cyc < 70) ? 1'($urandom_range(0, 1)) : 1'b0;
      out_ready = (cyc < 70) ? 1'($urandom_range(0, 2) != 0) : 1'b1;
      in_data   = seq;
      in_ctrl   = 8'hFF;
      #5;
      if (!out_valid) chk("bubble ctrl", out_ctrl, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("scoreboard underflow", out_data, 0);
        else begin
          chk("order", out_data, sb[0]);
          void'(sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        seq = seq + 1;
      end
    end
    chk("drain empty", sb.size(), 0);
    in_valid = 0;

    // Single-entry variant: combinational in_ready and back-to-back replacement
    @(posedge clk); #1;
    z_in_valid = 1; z_in_data = 'h200; z_in_ctrl = 8'h08; z_out_ready = 0;
    @(posedge clk); #1;
    chk("z load valid", z_out_valid, 1);
    chk("z load data", z_out_data, 'h200);
    chk("z stall in_ready", z_in_ready, 0);
    z_out_ready = 1; z_in_data = 'h201;
    #1 chk("z release in_ready", z_in_ready, 1);
    @(posedge clk); #1;
    chk("z b2b data 1", z_out_data, 'h201);
    chk("z b2b valid 1", z_out_valid, 1);
    z_in_data = 'h202;
    @(posedge clk); #1;
    chk("z b2b data 2", z_out_data, 'h202);
    z_in_valid = 0;
    @(posedge clk); #1;
    chk("z drained valid", z_out_valid, 0);
    chk("z drained ctrl", z_out_ctrl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
